// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the request/response handshake and the SRAM/IO bus signals of the
// memory-access sequencer.
//   req_valid/req_ready/req_we/req_addr/req_wdata : request handshake
//   rsp_valid/rsp_ready/rsp_rdata                 : response handshake
//   mem_addr/mem_wdata/mem_mem_ena/mem_wr_ena     : bus drive
//   mem_rdata                                     : bus read data
// Modports:
//   slave  : the sequencer itself
//   master : the environment (requester plus memory) around it
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_mem_ena;
  logic                  mem_wr_ena;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
           mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
           mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Memory-access sequencer between the SLC-3 control FSM (MAR/MDR path) and
// the SRAM/IO bus. Accepts one read or write per request handshake, holds the
// bus enables for a configurable number of wait states, captures read data
// and returns a response under a valid/ready handshake.
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous, active-low reset (0 = reset)
//   bus          : mem_access_ctrl_if.slave (request, response, bus signals)
//   busy         : high whenever the sequencer is not idle
//   access_count : completed accesses, wraps modulo 2^CNT_WIDTH
// The interface instance must use the same DATA_WIDTH/ADDR_WIDTH as this
// module.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_ctrl_if.slave     bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] access_count
);

  localparam int MAX_LAT    = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int WAIT_W_RAW = $clog2(MAX_LAT + 1);
  localparam int WAIT_W     = (WAIT_W_RAW < 1) ? 1 : WAIT_W_RAW;

  // Terminal wait-count values: ACCESS ends on the edge where the counter
  // reaches LAT-1, so the enables are held for exactly LAT cycles.
  localparam logic [WAIT_W-1:0] RD_LAST = WAIT_W'(RD_LATENCY - 1);
  localparam logic [WAIT_W-1:0] WR_LAST = WAIT_W'(WR_LATENCY - 1);

  if (RD_LATENCY < 1) begin : g_bad_rd_latency
    $error("mem_access_ctrl: RD_LATENCY must be >= 1");
  end
  if (WR_LATENCY < 1) begin : g_bad_wr_latency
    $error("mem_access_ctrl: WR_LATENCY must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("mem_access_ctrl: CNT_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              we_lat;
  logic              last_beat;

  // The terminal count depends only on registered state, so no request or
  // response input can reach an output combinationally.
  assign last_beat = we_lat ? (wait_cnt == WR_LAST) : (wait_cnt == RD_LAST);

  assign busy = (state != S_IDLE);

  // Single sequencing process. Every bus-facing output is a register updated
  // here, so the enables drop the moment reset asserts, even mid-access, and
  // mem_addr/mem_wdata only change when a new request is latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      we_lat          <= 1'b0;
      bus.req_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_mem_ena <= 1'b0;
      bus.mem_wr_ena  <= 1'b0;
      access_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            state           <= S_ACCESS;
            wait_cnt        <= '0;
            we_lat          <= bus.req_we;
            bus.mem_addr    <= bus.req_addr;
            bus.mem_wdata   <= bus.req_wdata;
            bus.req_ready   <= 1'b0;
            bus.mem_mem_ena <= 1'b1;
            bus.mem_wr_ena  <= bus.req_we;
          end
        end

        S_ACCESS: begin
          if (last_beat) begin
            state           <= S_RESP;
            bus.mem_mem_ena <= 1'b0;
            bus.mem_wr_ena  <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            if (!we_lat) begin
              bus.rsp_rdata <= bus.mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            access_count  <= access_count + 1'b1;
          end
        end

        default: begin
          state           <= S_IDLE;
          bus.rsp_valid   <= 1'b0;
          bus.req_ready   <= 1'b1;
          bus.mem_mem_ena <= 1'b0;
          bus.mem_wr_ena  <= 1'b0;
        end
      endcase
    end
  end

endmodule
